// File: rtl/path_pkg.sv
`default_nettype none
// ============================================================================
// path_pkg : shared types and bus constants for the path capture buffer
// Rev 1.0
// ============================================================================

package path_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    STREAM  = 2'd2
  } path_state_e;

  localparam logic [31:0] NODE_ADDR_DEF = 32'h0200_0008;
  localparam logic [31:0] CMD_ADDR_DEF  = 32'h0200_000C;

  localparam int unsigned CMD_COMMIT = 1;
  localparam int unsigned CMD_ABORT  = 0;

endpackage

`default_nettype wire

// File: rtl/path_store.sv
`default_nettype none
// ============================================================================
// path_store : node register array, one write port, combinational stream read
//              port and registered debug read port
// Rev 1.0
// ============================================================================

module path_store #(
  parameter int DATA_W    = 32,
  parameter int MAX_NODES = 16,
  parameter int IDX_W     = $clog2(MAX_NODES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o,
  input  logic [IDX_W-1:0]  dbg_idx_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  logic [DATA_W-1:0] mem_q [MAX_NODES];
  logic [DATA_W-1:0] dbg_q;

  // Contents survive reset; only the debug output register is cleared.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dbg_q <= '0;
    end else begin
      dbg_q <= mem_q[dbg_idx_i];
    end
  end

  assign rdata_o    = mem_q[raddr_i];
  assign dbg_data_o = dbg_q;

endmodule

`default_nettype wire

// File: rtl/path_capture_buffer.sv
`default_nettype none
// ============================================================================
// path_capture_buffer : captures node words from the CPU store bus, then
//                       streams a committed path over valid/ready
// Rev 1.0
// ============================================================================

module path_capture_buffer
  import path_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                MAX_NODES = 16,
  parameter logic [ADDR_W-1:0] NODE_ADDR = ADDR_W'(NODE_ADDR_DEF),
  parameter logic [ADDR_W-1:0] CMD_ADDR  = ADDR_W'(CMD_ADDR_DEF),
  localparam int               IDX_W     = $clog2(MAX_NODES),
  localparam int               CNT_W     = $clog2(MAX_NODES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] DataAdr,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] node_data,
  output logic              node_valid,
  input  logic              node_ready,
  output logic [CNT_W-1:0]  path_len,
  output logic              path_found,
  output logic              err,
  input  logic [IDX_W-1:0]  dbg_idx,
  output logic [DATA_W-1:0] dbg_data
);

  path_state_e       state_q, state_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [IDX_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              err_q, err_d;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;

  logic w_node_wr, w_commit, w_abort, w_last;

  assign w_node_wr = MemWrite && (DataAdr == NODE_ADDR);
  assign w_commit  = MemWrite && (DataAdr == CMD_ADDR) && (WriteData == DATA_W'(CMD_COMMIT));
  assign w_abort   = MemWrite && (DataAdr == CMD_ADDR) && (WriteData == DATA_W'(CMD_ABORT));
  assign w_last    = (CNT_W'(rd_ptr_q) == (len_q - CNT_W'(1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      len_q    <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      rd_ptr_q <= rd_ptr_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    rd_ptr_d  = rd_ptr_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_waddr = '0;
    case (state_q)
      IDLE: begin
        if (w_node_wr) begin
          mem_we  = 1'b1;
          len_d   = CNT_W'(1);
          err_d   = 1'b0;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (w_node_wr) begin
          if (len_q < CNT_W'(MAX_NODES)) begin
            mem_we    = 1'b1;
            mem_waddr = IDX_W'(len_q);
            len_d     = len_q + CNT_W'(1);
          end else begin
            err_d = 1'b1;
          end
        end else if (w_commit) begin
          rd_ptr_d = '0;
          state_d  = STREAM;
        end else if (w_abort) begin
          len_d   = '0;
          state_d = IDLE;
        end
      end
      STREAM: begin
        // The buffer is read-only while streaming; stray node writes only flag.
        if (w_node_wr) begin
          err_d = 1'b1;
        end
        if (node_ready) begin
          rd_ptr_d = rd_ptr_q + IDX_W'(1);
          if (w_last) begin
            rd_ptr_d = '0;
            len_d    = '0;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  path_store #(
    .DATA_W    (DATA_W),
    .MAX_NODES (MAX_NODES),
    .IDX_W     (IDX_W)
  ) u_store (
    .clk        (clk),
    .reset      (reset),
    .we_i       (mem_we),
    .waddr_i    (mem_waddr),
    .wdata_i    (WriteData),
    .raddr_i    (rd_ptr_q),
    .rdata_o    (node_data),
    .dbg_idx_i  (dbg_idx),
    .dbg_data_o (dbg_data)
  );

  assign node_valid = (state_q == STREAM);
  assign path_found = (state_q == STREAM);
  assign path_len   = len_q;
  assign err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_path_capture_buffer.sv
`default_nettype none
// ============================================================================
// tb_path_capture_buffer : randomized and directed bench with a queue model
// Rev 1.0
// ============================================================================

module tb_path_capture_buffer;

  localparam int MN = 4;
  localparam int IW = 2;
  localparam int CW = 3;
  localparam logic [31:0] NADR = 32'h0200_0008;
  localparam logic [31:0] CADR = 32'h0200_000C;
  localparam logic [31:0] OADR = 32'h0200_0004;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          MemWrite = 1'b0;
  logic [31:0]   DataAdr = '0;
  logic [31:0]   WriteData = '0;
  logic          node_ready = 1'b0;
  logic [IW-1:0] dbg_idx = '0;
  logic [31:0]   node_data;
  logic          node_valid;
  logic [CW-1:0] path_len;
  logic          path_found;
  logic          err;
  logic [31:0]   dbg_data;

  path_capture_buffer #(
    .DATA_W    (32),
    .ADDR_W    (32),
    .MAX_NODES (MN),
    .NODE_ADDR (NADR),
    .CMD_ADDR  (CADR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWrite   (MemWrite),
    .DataAdr    (DataAdr),
    .WriteData  (WriteData),
    .node_data  (node_data),
    .node_valid (node_valid),
    .node_ready (node_ready),
    .path_len   (path_len),
    .path_found (path_found),
    .err        (err),
    .dbg_idx    (dbg_idx),
    .dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: the path is a queue; streaming walks an index through it.
  logic [31:0] m_q[$];
  bit          m_open = 1'b0;
  bit          m_stream = 1'b0;
  bit          m_err = 1'b0;
  int          m_rd = 0;
  logic [31:0] m_mem[MN];
  bit          m_known[MN];
  logic [31:0] m_dbg = '0;
  bit          m_dbg_known = 1'b0;
  bit          m_live = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit nw, cw;
    if (reset) begin
      m_open = 0; m_stream = 0; m_err = 0; m_rd = 0;
      m_q.delete();
      m_dbg = '0; m_dbg_known = 1; m_live = 1;
      return;
    end
    m_dbg       = m_mem[dbg_idx];
    m_dbg_known = m_known[dbg_idx];
    nw = MemWrite && DataAdr == NADR;
    cw = MemWrite && DataAdr == CADR;
    if (m_stream) begin
      if (nw) m_err = 1;
      if (node_ready) begin
        m_rd++;
        if (m_rd == m_q.size()) begin
          m_stream = 0; m_rd = 0;
          m_q.delete();
        end
      end
    end else if (m_open) begin
      if (nw) begin
        if (m_q.size() < MN) begin
          m_mem[m_q.size()] = WriteData;
          m_known[m_q.size()] = 1;
          m_q.push_back(WriteData);
        end else begin
          m_err = 1;
        end
      end else if (cw && WriteData == 32'd1) begin
        m_open = 0; m_stream = 1; m_rd = 0;
      end else if (cw && WriteData == 32'd0) begin
        m_open = 0;
        m_q.delete();
      end
    end else if (nw) begin
      m_q.delete();
      m_q.push_back(WriteData);
      m_mem[0] = WriteData; m_known[0] = 1;
      m_err = 0; m_open = 1;
    end
  endtask

  always @(negedge clk) begin
    if (m_live) begin
      check("node_valid", 32'(node_valid), 32'(m_stream));
      check("path_found", 32'(path_found), 32'(m_stream));
      check("path_len", 32'(path_len), 32'(m_q.size()));
      check("err", 32'(err), 32'(m_err));
      if (m_stream) check("node_data", node_data, m_q[m_rd]);
      if (m_dbg_known) check("dbg_data", dbg_data, m_dbg);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    dbg_idx = IW'($urandom_range(0, MN - 1));
  endtask

  task automatic bus(input logic [31:0] adr, input logic [31:0] v);
    MemWrite = 1; DataAdr = adr; WriteData = v;
    tick();
    MemWrite = 0; DataAdr = '0; WriteData = '0;
  endtask

  logic [31:0] got[$];
  logic [31:0] exp4[4];
  int xfers;

  initial begin
    for (int i = 0; i < MN; i++) m_known[i] = 0;

    // Reset
    reset = 1; tick(); tick();
    check("rst_len", 32'(path_len), 32'd0);
    check("rst_valid", 32'(node_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_dbg", dbg_data, 32'd0);
    reset = 0;

    // Capture 5,3,7 and stream at full rate
    node_ready = 1;
    bus(NADR, 32'd5); bus(NADR, 32'd3); bus(NADR, 32'd7);
    check("cap_len3", 32'(path_len), 32'd3);
    bus(CADR, 32'd1);
    check("commit_found", 32'(path_found), 32'd1);
    check("stream0", node_data, 32'd5);
    tick(); check("stream1", node_data, 32'd3);
    tick(); check("stream2", node_data, 32'd7);
    tick();
    check("done_found", 32'(path_found), 32'd0);
    check("done_len", 32'(path_len), 32'd0);

    // Backpressure with ready pattern 1,0,0
    node_ready = 0;
    for (int i = 0; i < 4; i++) begin
      exp4[i] = $urandom;
      bus(NADR, exp4[i]);
    end
    bus(CADR, 32'd1);
    got.delete(); xfers = 0;
    for (int i = 0; i < 20; i++) begin
      node_ready = (i % 3 == 0);
      if (node_valid && node_ready) begin
        xfers++;
        got.push_back(node_data);
      end
      tick();
    end
    node_ready = 0;
    check("bp_xfers", 32'(xfers), 32'd4);
    for (int i = 0; i < 4; i++) check("bp_order", (i < got.size()) ? got[i] : 32'hDEAD, exp4[i]);

    // Overflow
    for (int i = 0; i < 6; i++) bus(NADR, 32'(10 + i));
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_len", 32'(path_len), 32'd4);
    bus(CADR, 32'd1);
    node_ready = 1;
    for (int i = 0; i < 4; i++) begin
      check("ovf_stream", node_data, 32'(10 + i));
      tick();
    end
    check("ovf_done", 32'(node_valid), 32'd0);

    // Abort then restart, plus ignored command value
    bus(NADR, 32'h41); bus(NADR, 32'h42);
    check("new_path_err", 32'(err), 32'd0);
    bus(CADR, 32'd0);
    check("abort_len", 32'(path_len), 32'd0);
    bus(NADR, 32'd9);
    bus(CADR, 32'd2);
    check("cmd2_len", 32'(path_len), 32'd1);
    check("cmd2_valid", 32'(node_valid), 32'd0);
    bus(OADR, 32'd1);
    check("other_adr_valid", 32'(node_valid), 32'd0);
    bus(CADR, 32'd1);
    check("single_data", node_data, 32'd9);
    tick();
    check("single_done", 32'(path_found), 32'd0);

    // Writes while streaming
    node_ready = 0;
    bus(NADR, 32'h11); bus(NADR, 32'h12); bus(NADR, 32'h13);
    bus(CADR, 32'd1);
    bus(NADR, 32'h20);
    check("ws_err", 32'(err), 32'd1);
    check("ws_data", node_data, 32'h11);
    check("ws_len", 32'(path_len), 32'd3);
    node_ready = 1;
    tick(); tick(); tick();
    node_ready = 0;
    bus(NADR, 32'h30);
    check("ws_err_clear", 32'(err), 32'd0);
    bus(CADR, 32'd0);

    // Reset mid-stream
    bus(NADR, 32'h51); bus(NADR, 32'h52); bus(NADR, 32'h53);
    bus(CADR, 32'd1);
    node_ready = 1; tick(); node_ready = 0;
    check("pre_rst_data", node_data, 32'h52);
    reset = 1; tick(); reset = 0;
    check("mrst_valid", 32'(node_valid), 32'd0);
    check("mrst_len", 32'(path_len), 32'd0);
    check("mrst_dbg", dbg_data, 32'd0);
    bus(CADR, 32'd1);
    check("empty_commit", 32'(node_valid), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int sel;
      reset      = ($urandom_range(0, 299) == 0);
      node_ready = $urandom_range(0, 1) == 1;
      MemWrite   = $urandom_range(0, 1) == 1;
      sel        = $urandom_range(0, 3);
      DataAdr    = (sel == 0) ? OADR : (sel == 1) ? CADR : NADR;
      WriteData  = (sel == 1) ? 32'($urandom_range(0, 2)) : $urandom;
      tick();
    end
    MemWrite = 0; reset = 0; node_ready = 0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/path_capture_buffer.md
# path_capture_buffer

Parametrised capture buffer for navigation paths that the RISC-V core writes over its memory-mapped store bus. Node words written to a node-port address are stored in order, up to a configurable depth. A write to a command address commits or aborts the path. A committed path is streamed to the downstream motion/navigation logic over a valid/ready handshake, and a registered random-access port is provided for debug.

## Interface
Parameters:
- DATA_W, 32, node word width
- ADDR_W, 32, bus address width
- MAX_NODES, 16, buffer depth (≥2)
- NODE_ADDR, 32'h0200_0008, node-port address
- CMD_ADDR, 32'h0200_000C, command address (1 = commit, 0 = abort, other values ignored)
- derived: IDX_W = $clog2(MAX_NODES), CNT_W = $clog2(MAX_NODES+1)

Ports (one clock; reset is synchronous, active-high):
- clk  in  1  sole clock; all state changes on rising edge
- reset  in  1  synchronous active-high reset
- MemWrite  in  1  CPU store strobe, stable for the whole cycle
- DataAdr  in  ADDR_W  store address
- WriteData  in  DATA_W  store data
- node_data  out  DATA_W  current streamed node
- node_valid  out  1  node_data valid
- node_ready  in  1  consumer accepts node_data
- path_len  out  CNT_W  nodes captured in the current path
- path_found  out  1  high from commit until last node is accepted
- err  out  1  sticky: overflow or write dropped while streaming
- dbg_idx  in  IDX_W  debug read index
- dbg_data  out  DATA_W  mem[dbg_idx], registered

## Operation
- States: IDLE, CAPTURE, STREAM.
- A node write is MemWrite && DataAdr==NODE_ADDR.
- A commit is MemWrite && DataAdr==CMD_ADDR && WriteData==1.
- An abort is the same command-address write with WriteData==0.
- IDLE:
  - Node write → mem[0]=WriteData, path_len=1, err cleared, go to CAPTURE.
  - Commit and abort are ignored.
- CAPTURE:
  - Node write with path_len<MAX_NODES → mem[path_len]=WriteData, path_len+1.
  - Node write with path_len==MAX_NODES → word dropped, err=1, path_len unchanged.
  - Commit → path_found=1, read pointer=0, go to STREAM.
  - Abort → path_len=0, go to IDLE. err is kept.
- STREAM:
  - node_valid=1 and node_data=mem[rd_ptr], combinational from the pointer.
  - node_valid && node_ready → rd_ptr+1.
  - Transfer of index path_len-1 → node_valid=0, path_found=0, path_len=0, go to IDLE.
  - Node writes in STREAM are dropped and set err=1.
  - Commit and abort in STREAM are ignored.
- A single store cannot hit both addresses. A store to any other address has no effect.
- Debug port: dbg_data <= mem[dbg_idx] every cycle. Indices ≥ path_len return stale contents.

## Timing
- Reset values: state=IDLE, path_len=0, rd_ptr=0, path_found=0, node_valid=0, err=0, dbg_data=0. Memory contents are not reset.
- Reset mid-capture or mid-stream discards the path. Reset has priority over every bus event in the same cycle.
- A node write at edge N is visible in path_len and at the debug port from N (dbg_data updates at N+1).
- A commit at edge C gives path_found=1, node_valid=1 and node_data=mem[0] after C. Zero added latency.
- Throughput is one node per cycle while node_ready is held high.
- node_valid is never dropped without a transfer, and node_data stays stable while valid && !ready.
- A node write in the same cycle as a STREAM handshake: the handshake proceeds, the write is dropped, err=1.
- A new path can begin on the cycle after the final transfer.

## Structure
- Package path_pkg:
  - path_state_e {IDLE, CAPTURE, STREAM}
  - default NODE_ADDR and CMD_ADDR
  - CMD_COMMIT=1 and CMD_ABORT=0
- Sub-module path_store: MAX_NODES×DATA_W register array with one write port, one combinational read port (stream) and one registered read port (debug).
- The FSM, counters and error flag live in path_capture_buffer.

## Test plan
- Capture and stream: write 5, 3, 7 to NODE_ADDR, then commit with node_ready=1 → path_found rises, node_data 5, 3, 7 on consecutive cycles, then path_found=0 and path_len=0.
- Backpressure: a 4-node path with node_ready toggling 1,0,0,1,… → each node is held stable while not ready, order is preserved, and exactly 4 transfers occur.
- Overflow: MAX_NODES=4, write 6 nodes (10…15), then commit → err=1, path_len=4, stream is 10, 11, 12, 13.
- Abort and restart: write 2 nodes, abort (CMD_ADDR ← 0), then write 9 and commit → a single-node stream of 9. Also check that writing value 2 to CMD_ADDR has no effect.
- Writes while streaming: write node 0x20 mid-stream with node_ready=0 → err=1 and the stream contents are unchanged. The next path's first node write clears err.
- Reset mid-stream: assert reset for 1 cycle after 1 of 3 transfers → all outputs at reset values on the next cycle, and a commit with no nodes is ignored.
